// File: rtl/onchip_mem_bist_master.sv
// Memory self-test initiator for a single-port on-chip RAM (Avalon-MM, 1-cycle read latency).
// It writes an incrementing pattern over a word range, reads it back and tallies the mismatches.
module onchip_mem_bist_master #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int CNT_W  = ADDR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [CNT_W-1:0]      num_words,
    input  logic [DATA_W-1:0]     seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_W-1:0]      err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic                  mem_clken
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

    // Requested lengths beyond the memory depth saturate to one full pass.
    function automatic logic [CNT_W-1:0] sat_len(input logic [CNT_W-1:0] n);
        return (n > DEPTH) ? DEPTH : n;
    endfunction

    logic [2:0]        state;
    logic [CNT_W-1:0]  len;          // clamped word count of the running test
    logic [CNT_W-1:0]  idx;          // accesses already issued in the current phase
    logic [ADDR_W-1:0] base_r;
    logic [DATA_W-1:0] seed_r;
    logic [ADDR_W-1:0] cur_addr;     // address of the next access to issue
    logic [DATA_W-1:0] cur_pat;      // pattern of the next access to issue
    logic [DATA_W-1:0] rd_pat;       // expected data of the read currently on the bus
    logic              vld_p0;
    logic [DATA_W-1:0] exp_data_p0;
    logic [ADDR_W-1:0] exp_addr_p0;
    logic [CNT_W-1:0]  start_len;
    logic              phase_end;
    logic              mismatch;

    assign start_len = sat_len(num_words);
    assign phase_end = (idx == len);
    assign mismatch  = vld_p0 && (mem_readdata != exp_data_p0);

    // Address/pattern generators and the one-cycle expected-data pipeline (no reset needed).
    always_ff @(posedge clk) begin
        // stage p0: expectation aligned with the cycle the RAM returns read data
        exp_data_p0 <= rd_pat;
        exp_addr_p0 <= mem_address;
        case (state)
            S_IDLE: begin
                if (start) begin
                    base_r   <= base_addr;
                    seed_r   <= seed;
                    cur_addr <= base_addr + ADDR_W'(1);
                    cur_pat  <= seed + DATA_W'(1);
                end
            end
            S_WRITE: begin
                if (phase_end) begin
                    rd_pat   <= seed_r;
                    cur_addr <= base_r + ADDR_W'(1);
                    cur_pat  <= seed_r + DATA_W'(1);
                end else begin
                    cur_addr <= cur_addr + ADDR_W'(1);
                    cur_pat  <= cur_pat + DATA_W'(1);
                end
            end
            S_READ: begin
                if (!phase_end) begin
                    rd_pat   <= cur_pat;
                    cur_addr <= cur_addr + ADDR_W'(1);
                    cur_pat  <= cur_pat + DATA_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Sequencer, registered bus outputs and result bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            len            <= '0;
            idx            <= '0;
            vld_p0         <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
            mem_clken      <= 1'b0;
        end else begin
            mem_clken <= 1'b1;
            done      <= 1'b0;
            // stage p0: a read on the bus this cycle is compared next cycle
            vld_p0    <= mem_chipselect && !mem_write;
            if (mismatch) begin
                err_count <= err_count + CNT_W'(1);
                if (err_count == '0) begin
                    first_err_addr <= exp_addr_p0;
                end
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_count      <= '0;
                        first_err_addr <= '0;
                        pass           <= 1'b0;
                        len            <= start_len;
                        if (start_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            pass  <= 1'b1;
                        end else begin
                            state          <= S_WRITE;
                            busy           <= 1'b1;
                            mem_chipselect <= 1'b1;
                            mem_write      <= 1'b1;
                            mem_byteenable <= '1;
                            mem_address    <= base_addr;
                            mem_writedata  <= seed;
                            idx            <= CNT_W'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (phase_end) begin
                        state       <= S_READ;
                        mem_write   <= 1'b0;
                        mem_address <= base_r;
                        idx         <= CNT_W'(1);
                    end else begin
                        mem_address   <= cur_addr;
                        mem_writedata <= cur_pat;
                        idx           <= idx + CNT_W'(1);
                    end
                end
                S_READ: begin
                    if (phase_end) begin
                        state          <= S_DRAIN;
                        mem_chipselect <= 1'b0;
                        mem_byteenable <= '0;
                    end else begin
                        mem_address <= cur_addr;
                        idx         <= idx + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // the last read's compare lands in this cycle, so fold it into pass
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0) && !mismatch;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_bist_master.sv
// Scoreboard bench for onchip_mem_bist_master: stimulus queues expected bus accesses and
// results, a negedge monitor pops and compares them as the DUT presents them.
module tb_onchip_mem_bist_master;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 14;
    localparam int BE_W   = 4;
    localparam int DEPTH  = 8192;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [CNT_W-1:0]  num_words = '0;
    logic [DATA_W-1:0] seed = '0;
    logic              busy, done, pass;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] first_err_addr;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] rdata = '0;

    typedef struct {
        int                cyc;
        bit                wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_t;

    typedef struct {
        int                cyc;
        bit                pass;
        logic [CNT_W-1:0]  err;
        logic [ADDR_W-1:0] first;
    } res_t;

    bus_t bq[$];
    res_t dq[$];
    bus_t eb;
    res_t er;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] flt [DEPTH];

    onchip_mem_bist_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_addr      (base_addr),
        .num_words      (num_words),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_readdata   (rdata),
        .mem_clken      (mem_clken)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal single-port RAM with 1-cycle read latency and per-address read fault masks.
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                rdata <= ram[mem_address] ^ flt[mem_address];
            end
        end
    end

    task automatic chk(input bit ok, input string msg);
        n_checks++;
        if (!ok) begin
            n_fails++;
            $display("FAIL %s", msg);
        end
    endtask

    function automatic bit all_zero();
        return ({busy, done, pass, err_count, first_err_addr, mem_address, mem_byteenable,
                 mem_chipselect, mem_write, mem_writedata, mem_clken} == '0);
    endfunction

    // Monitor: compare every bus access and every done pulse against the queued expectations.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_chipselect) begin
                if (bq.size() == 0) begin
                    chk(1'b0, $sformatf("unexp_bus cyc=%0d wr=%0b addr=%0d, required no access",
                                        cyc, mem_write, mem_address));
                end else begin
                    eb = bq.pop_front();
                    chk(cyc == eb.cyc && mem_write == eb.wr && mem_address == eb.addr &&
                        (!eb.wr || mem_writedata == eb.data) && mem_byteenable == '1 && busy,
                        $sformatf("bus got cyc=%0d wr=%0b addr=%0d data=%h be=%h busy=%0b want cyc=%0d wr=%0b addr=%0d data=%h be=f busy=1",
                                  cyc, mem_write, mem_address, mem_writedata, mem_byteenable, busy,
                                  eb.cyc, eb.wr, eb.addr, eb.data));
                end
            end else begin
                chk(mem_byteenable == '0, $sformatf("idle_be got %h want 0", mem_byteenable));
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk(1'b0, $sformatf("unexp_done cyc=%0d, required no done", cyc));
                end else begin
                    er = dq.pop_front();
                    chk(cyc == er.cyc && pass == er.pass && err_count == er.err &&
                        first_err_addr == er.first && !busy,
                        $sformatf("done got cyc=%0d pass=%0b err=%0d first=%0d busy=%0b want cyc=%0d pass=%0b err=%0d first=%0d busy=0",
                                  cyc, pass, err_count, first_err_addr, busy,
                                  er.cyc, er.pass, er.err, er.first));
                end
            end
        end
    end

    // Issue one test and queue its expected accesses and result; optionally pulse start
    // again during WRITE and during DONE, which must be ignored.
    task automatic run_test(input int base, input int n, input logic [DATA_W-1:0] sd,
                            input bit ep, input int ee, input int ef,
                            input bit ign_w, input bit ign_d);
        int   nn, c0;
        bus_t b;
        res_t r;
        nn = (n > DEPTH) ? DEPTH : n;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < nn; i++) begin
            b.cyc = c0 + 1 + i; b.wr = 1'b1;
            b.addr = ADDR_W'((base + i) % DEPTH); b.data = sd + DATA_W'(i);
            bq.push_back(b);
        end
        for (int i = 0; i < nn; i++) begin
            b.cyc = c0 + 1 + nn + i; b.wr = 1'b0;
            b.addr = ADDR_W'((base + i) % DEPTH); b.data = sd + DATA_W'(i);
            bq.push_back(b);
        end
        r.cyc = (nn == 0) ? c0 + 1 : c0 + 2 * nn + 2;
        r.pass = ep; r.err = CNT_W'(ee); r.first = ADDR_W'(ef);
        dq.push_back(r);
        base_addr = ADDR_W'(base); num_words = CNT_W'(n); seed = sd; start = 1'b1;
        @(negedge clk);
        start = 1'b0; base_addr = 13'h0AAA; num_words = 14'd3; seed = 32'hFFFF_0000;
        for (int k = 2; k <= 2 * nn + 4; k++) begin
            @(negedge clk);
            if (ign_w && k == 3) start = 1'b1;
            if (ign_w && k == 4) start = 1'b0;
            if (ign_d && k == 2 * nn + 2) start = 1'b1;
            if (ign_d && k == 2 * nn + 3) start = 1'b0;
        end
        chk(bq.size() == 0 && dq.size() == 0,
            $sformatf("complete base=%0d n=%0d pending bus=%0d done=%0d want 0 0",
                      base, n, bq.size(), dq.size()));
        chk(pass == ep && err_count == CNT_W'(ee) && first_err_addr == ADDR_W'(ef),
            $sformatf("hold got pass=%0b err=%0d first=%0d want pass=%0b err=%0d first=%0d",
                      pass, err_count, first_err_addr, ep, ee, ef));
    endtask

    initial begin
        int c0;
        bus_t b;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i] = '0;
            flt[i] = '0;
        end

        repeat (3) @(negedge clk);
        chk(all_zero(), "reset_vals got nonzero output, want all outputs 0");
        reset_n = 1'b1;
        @(negedge clk);
        chk(mem_clken && !busy && !done && !mem_chipselect,
            $sformatf("post_reset got clken=%0b busy=%0b done=%0b cs=%0b want 1 0 0 0",
                      mem_clken, busy, done, mem_chipselect));

        // Basic test, wrap-around, injected faults, zero length
        run_test(0, 4, 32'h0000_1000, 1'b1, 0, 0, 1'b0, 1'b0);
        run_test(8190, 4, 32'hA5A5_0000, 1'b1, 0, 0, 1'b0, 1'b0);
        flt[5] = 32'h1;
        run_test(0, 8, 32'h0000_0100, 1'b0, 1, 5, 1'b0, 1'b0);
        flt[6] = 32'h1;
        run_test(0, 8, 32'h0000_0200, 1'b0, 2, 5, 1'b0, 1'b0);
        flt[5] = '0;
        flt[6] = '0;
        run_test(123, 0, 32'h0000_0005, 1'b1, 0, 0, 1'b0, 1'b0);

        // Extra start pulses during WRITE and DONE
        run_test(0, 4, 32'h0000_0077, 1'b1, 0, 0, 1'b1, 1'b1);

        // Reset in the middle of WRITE
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 2; i++) begin
            b.cyc = c0 + 1 + i; b.wr = 1'b1; b.addr = ADDR_W'(40 + i); b.data = 32'h3000 + DATA_W'(i);
            bq.push_back(b);
        end
        base_addr = 13'd40; num_words = 14'd8; seed = 32'h3000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk(all_zero(), "async_reset got nonzero output, want all outputs 0");
        chk(bq.size() == 0, $sformatf("pre_reset_writes pending=%0d want 0", bq.size()));
        bq.delete();
        dq.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (25) @(negedge clk);
        chk(!done && !busy && !mem_chipselect && mem_clken,
            $sformatf("abort_quiet got done=%0b busy=%0b cs=%0b clken=%0b want 0 0 0 1",
                      done, busy, mem_chipselect, mem_clken));
        run_test(20, 6, 32'hBEEF_0000, 1'b1, 0, 0, 1'b0, 1'b0);

        // Length above depth clamps to a full pass
        run_test(100, 9000, 32'hCAFE_0000, 1'b1, 0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion by %0t, want summary before then", $time);
        $fatal(1, "watchdog");
    end

endmodule
